axi_lite_cmd_arbiter: RTL

- Round-robin arbiter that shares one axi_lite_master user command port among NUM_REQ independent requesters.
- Each requester uses a 4-phase level handshake. The arbiter latches the winning command and drives the master's command interface.
- It waits for the master's ack, then waits for the master to return non-busy, and returns read data and error to the winner.
- A timeout guards against a hung slave so that no requester can lock the bus.

---
 rtl/axi_lite_cmd_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite master command port among
// NUM_REQ level-handshake requesters, with a hung-slave timeout.
module axi_lite_cmd_arbiter #(
    parameter int          NUM_REQ         = 4,
    parameter int          ADDR_WIDTH      = 32,
    parameter logic [31:0] DEFAULT_TIMEOUT = 32'd100000000
) (
    input  logic                          clk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            i_req_en,
    input  logic [NUM_REQ-1:0]            i_req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*4-1:0]          i_req_byte_en,
    input  logic [NUM_REQ*32-1:0]         i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ack,
    output logic [NUM_REQ-1:0]            o_req_error,
    output logic [31:0]                   o_req_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy,
    output logic                          o_timeout,
    output logic                          o_m_cmd_en,
    output logic                          o_m_cmd_wr_rd,
    output logic [ADDR_WIDTH-1:0]         o_m_cmd_addr,
    output logic [3:0]                    o_m_cmd_byte_en,
    output logic [31:0]                   o_m_cmd_data,
    output logic [31:0]                   o_m_cmd_data_count,
    input  logic                          i_m_cmd_ack,
    input  logic                          i_m_cmd_error,
    input  logic [31:0]                   i_m_cmd_data,
    input  logic [31:0]                   i_m_cmd_status
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE,
        RESPOND
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     cand;
    logic               win_found;
    logic [NUM_REQ-1:0] grant;
    logic [31:0]        tmo_cnt;
    logic               tmo_hit;
    logic               ack_ok;
    logic               abort;
    logic               grant_go;
    logic               cmd_en_q;
    logic               err_q;
    logic               m_busy;
    logic               unused_status;

    assign m_busy        = i_m_cmd_status[0];
    assign unused_status = ^i_m_cmd_status[31:1];

    assign o_m_cmd_data_count = 32'd1;
    assign o_busy      = (state != IDLE);
    assign o_grant     = grant;
    assign o_req_ack   = (state == RESPOND) ? grant : '0;
    assign o_req_error = (state == RESPOND && err_q) ? grant : '0;

    assign tmo_hit = (tmo_cnt == DEFAULT_TIMEOUT - 32'd1);

    // The master holds ack high after a completion, so only trust it once
    // cmd_en has been visible to the master for a full cycle.
    assign ack_ok = o_m_cmd_en && cmd_en_q && i_m_cmd_ack;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_found && i_req_en[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_go   = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_found && !m_busy) begin
                    grant_go   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_ok) begin
                    state_next = RELEASE;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    state_next = RESPOND;
                end
            end
            RELEASE: begin
                if (!m_busy) begin
                    state_next = RESPOND;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                if (!i_req_en[owner]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            state           <= IDLE;
            ptr             <= IDX_W'(NUM_REQ - 1);
            owner           <= '0;
            grant           <= '0;
            tmo_cnt         <= '0;
            cmd_en_q        <= 1'b0;
            err_q           <= 1'b0;
            o_timeout       <= 1'b0;
            o_req_data      <= '0;
            o_m_cmd_en      <= 1'b0;
            o_m_cmd_wr_rd   <= 1'b0;
            o_m_cmd_addr    <= '0;
            o_m_cmd_byte_en <= '0;
            o_m_cmd_data    <= '0;
        end else begin
            state      <= state_next;
            o_timeout  <= abort;
            cmd_en_q   <= o_m_cmd_en;
            o_m_cmd_en <= (state == ISSUE) && (state_next == ISSUE);

            if ((state == ISSUE || state == RELEASE) && state_next == state) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end else begin
                tmo_cnt <= '0;
            end

            if (grant_go) begin
                ptr             <= win_idx;
                owner           <= win_idx;
                grant           <= NUM_REQ'(1) << win_idx;
                o_m_cmd_wr_rd   <= i_req_wr_rd[win_idx];
                o_m_cmd_addr    <= i_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                o_m_cmd_byte_en <= i_req_byte_en[win_idx*4 +: 4];
                o_m_cmd_data    <= i_req_data[win_idx*32 +: 32];
            end

            if (state == ISSUE && ack_ok) begin
                o_req_data <= i_m_cmd_data;
                err_q      <= i_m_cmd_error;
            end

            if (abort) begin
                o_req_data <= '0;
                err_q      <= 1'b1;
            end

            if (state == RESPOND && state_next == IDLE) begin
                grant <= '0;
            end
        end
    end

endmodule
